// File: rtl/axis_i2c_pkg.sv
// -----------------------------------------------------------------------------
// axis_i2c_pkg
// Shared types and widths for the I2C write-only target (axis_i2c_rx).
//   i2c_rx_state_t : receiver FSM states
//   I2C_ADDR_WIDTH : 7-bit target address
//   I2C_BYTE_WIDTH : one I2C byte / one AXIS beat
// -----------------------------------------------------------------------------
package axis_i2c_pkg;

    localparam int I2C_ADDR_WIDTH = 7;
    localparam int I2C_BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_rx_state_t;

endpackage

// File: rtl/axis_i2c_rx_if.sv
// -----------------------------------------------------------------------------
// axis_i2c_rx_if
// AXI-Stream byte channel carrying received I2C data bytes.
//   tdata  : received byte
//   tvalid : byte available (source -> sink)
//   tready : sink accepts (sink -> source)
// Modports: master (byte source, i.e. axis_i2c_rx), slave (downstream FIFO).
// -----------------------------------------------------------------------------
interface axis_i2c_rx_if;
    import axis_i2c_pkg::*;

    logic [I2C_BYTE_WIDTH-1:0] tdata;
    logic                      tvalid;
    logic                      tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_i2c_rx_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_bus_sync
// Brings the asynchronous SCL/SDA lines into the clk domain and derives
// single-clk event pulses from the synchronized levels.
//   clk, rst     : system clock, synchronous active-high reset
//   i_scl, i_sda : raw bus lines
//   o_sda        : synchronized SDA level
//   o_scl_rise   : synchronized SCL rising edge (1 clk)
//   o_scl_fall   : synchronized SCL falling edge (1 clk)
//   o_start      : SDA fell while SCL high (1 clk)
//   o_stop       : SDA rose while SCL high (1 clk)
// -----------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // Reset to the idle bus level (both lines high) so leaving reset on an
    // idle bus produces no spurious edge events.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old
            // value of its predecessor, which is what makes this a shift chain.
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    // SCL must be high on both samples so an SDA change racing SCL is not
    // mistaken for a START/STOP.
    assign o_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
    assign o_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;

endmodule

// File: rtl/axis_i2c_rx.sv
// -----------------------------------------------------------------------------
// axis_i2c_rx
// I2C write-only target. Receives address + data bytes from an external
// master, ACKs its own address (write only) and every byte it can buffer,
// and presents the bytes on an AXI-Stream master with a single-entry buffer.
//   clk, rst    : system clock, synchronous active-high reset
//   i2c_scl     : bus clock (asynchronous)
//   i2c_sda_i   : bus data (asynchronous)
//   i2c_sda_oe  : 1 = pull SDA low (ACK), 0 = release
//   m_axis      : AXIS master (tdata/tvalid/tready)
//   frame_end   : 1-clk pulse on STOP ending an addressed write
//   overflow    : 1-clk pulse when a byte is NACKed because the buffer is full
// -----------------------------------------------------------------------------
module axis_i2c_rx
    import axis_i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR = 7'h50,
    parameter int                        SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i2c_scl,
    input  logic                 i2c_sda_i,
    output logic                 i2c_sda_oe,
    axis_i2c_rx_if.master        m_axis,
    output logic                 frame_end,
    output logic                 overflow
);

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (i2c_scl),
        .i_sda      (i2c_sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_rx_state_t             r_state;
    i2c_rx_state_t             w_state_nxt;
    logic [2:0]                r_bit_cnt;
    logic                      r_byte_full;   // 8 bits captured, ACK slot pending
    logic [I2C_BYTE_WIDTH-1:0] r_shift;
    logic                      r_sda_oe;
    logic [I2C_BYTE_WIDTH-1:0] r_tdata;
    logic                      r_tvalid;
    logic                      r_frame_end;
    logic                      r_overflow;

    logic w_sda_oe_nxt;
    logic w_shift_en;
    logic w_clr_bits;
    logic w_load;
    logic w_overflow;
    logic w_frame_end;
    logic w_buf_free;

    // The buffer also counts as free when its current byte leaves this clk.
    assign w_buf_free = !r_tvalid || m_axis.tready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt  = r_state;
        w_sda_oe_nxt = r_sda_oe;
        w_shift_en   = 1'b0;
        w_clr_bits   = 1'b0;
        w_load       = 1'b0;
        w_overflow   = 1'b0;
        w_frame_end  = 1'b0;

        if (w_start) begin
            w_state_nxt  = ADDR;
            w_sda_oe_nxt = 1'b0;
            w_clr_bits   = 1'b1;
        end else if (w_stop) begin
            w_state_nxt  = IDLE;
            w_sda_oe_nxt = 1'b0;
            w_clr_bits   = 1'b1;
            w_frame_end  = (r_state == DATA) || (r_state == DATA_ACK);
        end else begin
            unique case (r_state)
                ADDR, DATA: begin
                    if (w_scl_rise && !r_byte_full) begin
                        w_shift_en = 1'b1;
                    end else if (w_scl_fall && r_byte_full) begin
                        // End of the 8th bit: decide ACK/NACK for the 9th clock.
                        w_clr_bits = 1'b1;
                        if (r_state == ADDR) begin
                            if (r_shift[7:1] == TARGET_ADDR && !r_shift[0]) begin
                                w_state_nxt  = ADDR_ACK;
                                w_sda_oe_nxt = 1'b1;
                            end else begin
                                w_state_nxt  = IGNORE;
                            end
                        end else if (w_buf_free) begin
                            w_state_nxt  = DATA_ACK;
                            w_sda_oe_nxt = 1'b1;
                            w_load       = 1'b1;
                        end else begin
                            w_state_nxt  = IGNORE;
                            w_overflow   = 1'b1;
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // Release SDA at the end of the ACK clock.
                    if (w_scl_fall) begin
                        w_state_nxt  = DATA;
                        w_sda_oe_nxt = 1'b0;
                    end
                end
                IDLE, IGNORE: begin
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_byte_full <= 1'b0;
            r_shift     <= '0;
            r_sda_oe    <= 1'b0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_frame_end <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_frame_end <= w_frame_end;
            r_overflow  <= w_overflow;

            if (w_clr_bits) begin
                r_bit_cnt   <= '0;
                r_byte_full <= 1'b0;
            end else if (w_shift_en) begin
                r_shift     <= {r_shift[I2C_BYTE_WIDTH-2:0], w_sda};
                r_bit_cnt   <= r_bit_cnt + 3'd1;
                r_byte_full <= (r_bit_cnt == 3'd7);
            end

            if (w_load) begin
                r_tdata  <= r_shift;
                r_tvalid <= 1'b1;
            end else if (r_tvalid && m_axis.tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign i2c_sda_oe    = r_sda_oe;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign frame_end     = r_frame_end;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_axis_i2c_rx.sv
// -----------------------------------------------------------------------------
// tb_axis_i2c_rx
// Bench for axis_i2c_rx: an I2C master drives an open-drain bus, a table of
// write transactions is applied in a loop, and hand-written sequences cover
// overflow, repeated START and reset during an ACK.
// -----------------------------------------------------------------------------
module tb_axis_i2c_rx;
    import axis_i2c_pkg::*;

    localparam int Q = 20;   // quarter SCL period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_bus;
    logic i2c_sda_oe;
    logic frame_end;
    logic overflow;

    axis_i2c_rx_if m_if ();

    // Wired-AND open-drain SDA.
    assign sda_bus = m_sda & ~i2c_sda_oe;

    axis_i2c_rx #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i2c_scl    (scl),
        .i2c_sda_i  (sda_bus),
        .i2c_sda_oe (i2c_sda_oe),
        .m_axis     (m_if),
        .frame_end  (frame_end),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- monitor (single writer of its own counters) ----------
    logic [7:0] rx_mem [256];
    int rx_wr = 0;
    int fe_cnt = 0;
    int ovf_cnt = 0;
    int oe_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_if.tvalid && m_if.tready) begin
                rx_mem[rx_wr[7:0]] = m_if.tdata;
                rx_wr = rx_wr + 1;
            end
            if (frame_end) fe_cnt = fe_cnt + 1;
            if (overflow) ovf_cnt = ovf_cnt + 1;
            if (i2c_sda_oe) oe_cnt = oe_cnt + 1;
        end
    end

    // ---------------- checking ---------------------------------------------
    int n_cmp = 0;
    int n_err = 0;
    int rx_rd = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pop expected bytes against bytes the DUT handed out.
    task automatic drain(input string name);
        logic [7:0] e;
        while (exp_q.size() > 0 && rx_rd < rx_wr) begin
            e = exp_q.pop_front();
            check({name, "_tdata"}, {24'd0, rx_mem[rx_rd[7:0]]}, {24'd0, e});
            rx_rd++;
        end
        check({name, "_missing"}, exp_q.size(), 0);
        check({name, "_extra"}, rx_wr - rx_rd, 0);
        exp_q.delete();
        rx_rd = rx_wr;
    endtask

    // ---------------- I2C master BFM ---------------------------------------
    task automatic wait_q();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wait_q();
        scl   = 1'b1; wait_q(); wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        m_sda = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        ack   = ~sda_bus;
        wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic set_tready(input logic v);
        @(posedge clk); #1;
        m_if.tready = v;
    endtask

    // ---------------- vector table -----------------------------------------
    typedef struct {
        logic [6:0] addr;
        logic       rw;
        int         nbytes;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
        int         exp_fe;
    } tr_t;

    tr_t vec [7];

    task automatic run_tr(input tr_t t, input string name);
        int fe0, ovf0, oe0;
        logic ack;
        logic [7:0] d;
        fe0 = fe_cnt; ovf0 = ovf_cnt; oe0 = oe_cnt;
        i2c_start();
        write_byte({t.addr, t.rw}, ack);
        check({name, "_addr_ack"}, {31'd0, ack}, {31'd0, t.exp_ack});
        if (t.exp_ack) begin
            for (int i = 0; i < t.nbytes; i++) begin
                d = (i == 0) ? t.d0 : t.d1;
                exp_q.push_back(d);
                write_byte(d, ack);
                check({name, "_data_ack"}, {31'd0, ack}, 32'd1);
            end
        end
        i2c_stop();
        repeat (10) @(posedge clk);
        check({name, "_frame_end"}, fe_cnt - fe0, t.exp_fe);
        check({name, "_overflow"}, ovf_cnt - ovf0, 0);
        if (!t.exp_ack) check({name, "_oe_cycles"}, oe_cnt - oe0, 0);
        drain(name);
    endtask

    initial begin
        logic ack;
        logic [7:0] b;
        int fe0, ovf0;

        vec[0] = '{7'h50, 1'b0, 2, 8'hA5, 8'h3C, 1'b1, 1};
        vec[1] = '{7'h51, 1'b0, 1, 8'h55, 8'h00, 1'b0, 0};
        vec[2] = '{7'h50, 1'b1, 1, 8'h00, 8'h00, 1'b0, 0};
        vec[3] = '{7'h50, 1'b0, 1, 8'h00, 8'h00, 1'b1, 1};
        vec[4] = '{7'h50, 1'b0, 2, 8'hFF, 8'h81, 1'b1, 1};
        vec[5] = '{7'h28, 1'b0, 1, 8'h12, 8'h00, 1'b0, 0};
        vec[6] = '{7'h50, 1'b0, 1, 8'h80, 8'h00, 1'b1, 1};

        m_if.tready = 1'b1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_sda_oe", {31'd0, i2c_sda_oe}, 32'd0);
        check("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        check("rst_tdata", {24'd0, m_if.tdata}, 32'd0);
        check("rst_frame_end", {31'd0, frame_end}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (10) @(posedge clk);

        for (int i = 0; i < 7; i++) run_tr(vec[i], $sformatf("vec%0d", i));

        // Overflow: buffer held with tready=0, second byte NACKed.
        set_tready(1'b0);
        fe0 = fe_cnt; ovf0 = ovf_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        check("ovf_addr_ack", {31'd0, ack}, 32'd1);
        exp_q.push_back(8'h11);
        write_byte(8'h11, ack);
        check("ovf_ack_11", {31'd0, ack}, 32'd1);
        write_byte(8'h22, ack);
        check("ovf_nack_22", {31'd0, ack}, 32'd0);
        i2c_stop();
        repeat (10) @(posedge clk);
        check("ovf_pulses", ovf_cnt - ovf0, 1);
        check("ovf_frame_end", fe_cnt - fe0, 0);
        check("ovf_tvalid_held", {31'd0, m_if.tvalid}, 32'd1);
        check("ovf_tdata_held", {24'd0, m_if.tdata}, 32'h11);
        set_tready(1'b1);
        repeat (5) @(posedge clk);
        drain("ovf");

        // Repeated START in the middle of a byte.
        fe0 = fe_cnt;
        i2c_start();
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_start();
        write_byte(8'hA0, ack);
        check("rs_addr_ack", {31'd0, ack}, 32'd1);
        exp_q.push_back(8'h7E);
        write_byte(8'h7E, ack);
        check("rs_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        repeat (10) @(posedge clk);
        check("rs_frame_end", fe_cnt - fe0, 1);
        drain("rs");

        // Reset while the DUT drives a data ACK.
        set_tready(1'b0);
        i2c_start();
        write_byte(8'hA0, ack);
        check("rr_addr_ack", {31'd0, ack}, 32'd1);
        b = 8'h99;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        check("rr_pre_oe", {31'd0, i2c_sda_oe}, 32'd1);
        check("rr_pre_tvalid", {31'd0, m_if.tvalid}, 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rr_oe_released", {31'd0, i2c_sda_oe}, 32'd0);
        check("rr_tvalid_cleared", {31'd0, m_if.tvalid}, 32'd0);
        check("rr_tdata_cleared", {24'd0, m_if.tdata}, 32'd0);
        m_sda = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        @(negedge clk); rst = 1'b0;
        set_tready(1'b1);
        repeat (10) @(posedge clk);
        rx_rd = rx_wr;
        run_tr('{7'h50, 1'b0, 1, 8'h42, 8'h00, 1'b1, 1}, "rr_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
